// File: rtl/dispatcher_for_in_req.sv
// IN_req receive dispatcher: steers each multi-flit message from the IN_req
// FIFO to exactly one download register (ic, dc or mem), or discards it.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   IN_req_rdy          FIFO head flit valid
//   IN_req_ctrl[1:0]    head flit ctrl, 2'b11 marks the tail
//   IN_req_dest[1:0]    destination, read on a message's first flit only
//                       (00 ic, 01 dc, 10 mem, 11 illegal)
//   ic/dc/mem_dl_rdy    download register can take a flit
//   ack_IN_req          pop the FIFO this cycle
//   v_ic/dc/mem_dl      write the current flit into that download register
//   select[2:0]         one-hot datapath mux (100 ic, 010 dc, 001 mem)
//   err_dest, err_len   sticky flags: illegal destination / over-length message
module dispatcher_for_in_req #(
    parameter int MAX_FLITS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IN_req_rdy,
    input  logic [1:0] IN_req_ctrl,
    input  logic [1:0] IN_req_dest,
    input  logic       ic_dl_rdy,
    input  logic       dc_dl_rdy,
    input  logic       mem_dl_rdy,
    output logic       ack_IN_req,
    output logic       v_ic_dl,
    output logic       v_dc_dl,
    output logic       v_mem_dl,
    output logic [2:0] select,
    output logic       err_dest,
    output logic       err_len
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        IC_DL  = 5'b00010,
        DC_DL  = 5'b00100,
        MEM_DL = 5'b01000,
        DROP   = 5'b10000
    } state_t;

    localparam logic [4:0] MAX_W = 5'(MAX_FLITS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_flit_cnt;
    logic [3:0] w_flit_cnt_nxt;
    logic       r_err_dest;
    logic       r_err_len;
    logic       w_err_dest_set;
    logic       w_err_len_set;
    logic       w_ack;
    logic       w_v_ic;
    logic       w_v_dc;
    logic       w_v_mem;
    logic       w_tail;
    logic       w_dl_rdy;
    logic [4:0] w_cnt_inc;

    assign w_tail    = (IN_req_ctrl == 2'b11);
    assign w_cnt_inc = {1'b0, r_flit_cnt} + 5'd1;

    // Only the locked target's rdy matters inside a message.
    assign w_dl_rdy = ((r_state == IC_DL)  && ic_dl_rdy)  ||
                      ((r_state == DC_DL)  && dc_dl_rdy)  ||
                      ((r_state == MEM_DL) && mem_dl_rdy);

    always_comb begin
        w_state_nxt    = r_state;
        w_flit_cnt_nxt = r_flit_cnt;
        w_err_dest_set = 1'b0;
        w_err_len_set  = 1'b0;
        w_ack          = 1'b0;
        w_v_ic         = 1'b0;
        w_v_dc         = 1'b0;
        w_v_mem        = 1'b0;
        unique case (1'b1)
            (r_state == IDLE): begin
                if (IN_req_rdy) begin
                    unique case (IN_req_dest)
                        2'b00: if (ic_dl_rdy) begin
                            w_ack  = 1'b1;
                            w_v_ic = 1'b1;
                            if (!w_tail) begin
                                w_state_nxt    = IC_DL;
                                w_flit_cnt_nxt = 4'd1;
                            end
                        end
                        2'b01: if (dc_dl_rdy) begin
                            w_ack  = 1'b1;
                            w_v_dc = 1'b1;
                            if (!w_tail) begin
                                w_state_nxt    = DC_DL;
                                w_flit_cnt_nxt = 4'd1;
                            end
                        end
                        2'b10: if (mem_dl_rdy) begin
                            w_ack   = 1'b1;
                            w_v_mem = 1'b1;
                            if (!w_tail) begin
                                w_state_nxt    = MEM_DL;
                                w_flit_cnt_nxt = 4'd1;
                            end
                        end
                        default: begin
                            w_ack          = 1'b1;
                            w_err_dest_set = 1'b1;
                            if (!w_tail) begin
                                w_state_nxt = DROP;
                            end
                        end
                    endcase
                end
            end
            (r_state == IC_DL),
            (r_state == DC_DL),
            (r_state == MEM_DL): begin
                if (IN_req_rdy && w_dl_rdy) begin
                    w_ack   = 1'b1;
                    w_v_ic  = (r_state == IC_DL);
                    w_v_dc  = (r_state == DC_DL);
                    w_v_mem = (r_state == MEM_DL);
                    if (w_tail) begin
                        w_state_nxt    = IDLE;
                        w_flit_cnt_nxt = 4'd0;
                    end else if (w_cnt_inc == MAX_W) begin
                        // Limit flit is delivered; the rest is discarded.
                        w_err_len_set = 1'b1;
                        w_state_nxt   = DROP;
                    end else begin
                        w_flit_cnt_nxt = w_cnt_inc[3:0];
                    end
                end
            end
            (r_state == DROP): begin
                if (IN_req_rdy) begin
                    w_ack = 1'b1;
                    if (w_tail) begin
                        w_state_nxt    = IDLE;
                        w_flit_cnt_nxt = 4'd0;
                    end
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_flit_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_flit_cnt <= 4'd0;
            r_err_dest <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_flit_cnt <= w_flit_cnt_nxt;
            r_err_dest <= r_err_dest | w_err_dest_set;
            r_err_len  <= r_err_len | w_err_len_set;
        end
    end

    // Mealy outputs are gated so nothing leaks out while reset is held.
    assign ack_IN_req = rst & w_ack;
    assign v_ic_dl    = rst & w_v_ic;
    assign v_dc_dl    = rst & w_v_dc;
    assign v_mem_dl   = rst & w_v_mem;
    assign select     = {v_ic_dl, v_dc_dl, v_mem_dl};
    assign err_dest   = r_err_dest;
    assign err_len    = r_err_len;

endmodule

// File: tb/tb_dispatcher_for_in_req.sv
// Directed self-checking bench for dispatcher_for_in_req.
// Observed vector: {ack, v_ic, v_dc, v_mem, select[2:0], err_dest, err_len}.
module tb_dispatcher_for_in_req;

    logic       clk;
    logic       rst;
    logic       IN_req_rdy;
    logic [1:0] IN_req_ctrl;
    logic [1:0] IN_req_dest;
    logic       ic_dl_rdy;
    logic       dc_dl_rdy;
    logic       mem_dl_rdy;
    logic       ack_IN_req;
    logic       v_ic_dl;
    logic       v_dc_dl;
    logic       v_mem_dl;
    logic [2:0] select;
    logic       err_dest;
    logic       err_len;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] NONE = 9'b0000_000_00;
    localparam logic [8:0] ACK  = 9'b1000_000_00;
    localparam logic [8:0] IC   = 9'b1100_100_00;
    localparam logic [8:0] DC   = 9'b1010_010_00;
    localparam logic [8:0] MEM  = 9'b1001_001_00;
    localparam logic [8:0] ED   = 9'b0000_000_10;
    localparam logic [8:0] EL   = 9'b0000_000_01;

    typedef struct packed {
        logic       rdy;
        logic [1:0] ctrl;
        logic [1:0] dest;
        logic       ic;
        logic       dc;
        logic       mem;
        logic [8:0] exp;
    } vec_t;

    dispatcher_for_in_req #(.MAX_FLITS(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .IN_req_rdy (IN_req_rdy),
        .IN_req_ctrl(IN_req_ctrl),
        .IN_req_dest(IN_req_dest),
        .ic_dl_rdy  (ic_dl_rdy),
        .dc_dl_rdy  (dc_dl_rdy),
        .mem_dl_rdy (mem_dl_rdy),
        .ack_IN_req (ack_IN_req),
        .v_ic_dl    (v_ic_dl),
        .v_dc_dl    (v_dc_dl),
        .v_mem_dl   (v_mem_dl),
        .select     (select),
        .err_dest   (err_dest),
        .err_len    (err_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] obs();
        return {ack_IN_req, v_ic_dl, v_dc_dl, v_mem_dl, select, err_dest, err_len};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        IN_req_rdy  = v.rdy;
        IN_req_ctrl = v.ctrl;
        IN_req_dest = v.dest;
        ic_dl_rdy   = v.ic;
        dc_dl_rdy   = v.dc;
        mem_dl_rdy  = v.mem;
        #2;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        IN_req_rdy  = 1'b0;
        IN_req_ctrl = 2'b00;
        IN_req_dest = 2'b00;
        ic_dl_rdy   = 1'b0;
        dc_dl_rdy   = 1'b0;
        mem_dl_rdy  = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        vec_t v [2];
        rst = 1'b0;
        v[0] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, NONE};
        v[1] = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b1, NONE};
        foreach (v[i]) begin
            drive(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs(), v[i].exp);
            end
            cyc();
        end
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        vec_t v [4];
        do_reset();
        v[0] = '{1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, DC};
        v[1] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, DC};
        v[2] = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, DC};
        v[3] = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, MEM};
        foreach (v[i]) begin
            drive(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL passthru[%0d]: got %b want %b", i, obs(), v[i].exp);
            end
            cyc();
        end
    endtask

    task automatic test_head_backpressure();
        vec_t v [7];
        do_reset();
        for (int i = 0; i < 4; i++)
            v[i] = '{1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, NONE};
        v[4] = '{1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, MEM};
        v[5] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, MEM};
        v[6] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, IC};
        foreach (v[i]) begin
            drive(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL head_bp[%0d]: got %b want %b", i, obs(), v[i].exp);
            end
            cyc();
        end
    endtask

    task automatic test_mid_backpressure();
        vec_t v [6];
        do_reset();
        v[0] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, IC};
        v[1] = '{1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, NONE};
        v[2] = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, NONE};
        v[3] = '{1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, IC};
        v[4] = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, IC};
        v[5] = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b1, DC};
        foreach (v[i]) begin
            drive(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL mid_bp[%0d]: got %b want %b", i, obs(), v[i].exp);
            end
            cyc();
        end
    endtask

    task automatic test_illegal_dest();
        vec_t v [5];
        do_reset();
        v[0] = '{1'b1, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1, ACK};
        v[1] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, NONE | ED};
        v[2] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, ACK | ED};
        v[3] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, IC | ED};
        v[4] = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b1, DC | ED};
        foreach (v[i]) begin
            drive(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL illegal[%0d]: got %b want %b", i, obs(), v[i].exp);
            end
            cyc();
        end
    endtask

    task automatic test_over_length();
        vec_t v;
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            if (k <= 11)
                v = '{1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, MEM};
            else if (k < 14)
                v = '{1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, ACK | EL};
            else if (k == 14)
                v = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, ACK | EL};
            else
                v = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, IC | EL};
            drive(v);
            checks++;
            if (obs() !== v.exp) begin
                errors++;
                $display("FAIL overlen[flit %0d]: got %b want %b", k, obs(), v.exp);
            end
            cyc();
        end
    endtask

    task automatic test_exact_max();
        vec_t v;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k < 11)
                v = '{1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, MEM};
            else if (k == 11)
                v = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, MEM};
            else
                v = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b1, DC};
            drive(v);
            checks++;
            if (obs() !== v.exp) begin
                errors++;
                $display("FAIL exactmax[flit %0d]: got %b want %b", k, obs(), v.exp);
            end
            cyc();
        end
    endtask

    task automatic test_async_reset();
        vec_t v [5];
        do_reset();
        v[0] = '{1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, ACK};
        v[1] = '{1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, DC | ED};
        v[2] = '{1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, DC | ED};
        v[3] = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, MEM};
        v[4] = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b1, DC};
        for (int i = 0; i < 3; i++) begin
            drive(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL arst_pre[%0d]: got %b want %b", i, obs(), v[i].exp);
            end
            if (i < 2) cyc();
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== NONE) begin
            errors++;
            $display("FAIL arst_hold: got %b want %b", obs(), NONE);
        end
        cyc();
        cyc();
        rst = 1'b1;
        for (int i = 3; i < 5; i++) begin
            drive(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL arst_post[%0d]: got %b want %b", i, obs(), v[i].exp);
            end
            cyc();
        end
    endtask

    initial begin
        rst         = 1'b0;
        IN_req_rdy  = 1'b0;
        IN_req_ctrl = 2'b00;
        IN_req_dest = 2'b00;
        ic_dl_rdy   = 1'b0;
        dc_dl_rdy   = 1'b0;
        mem_dl_rdy  = 1'b0;
        #1;
        test_reset();
        test_passthrough();
        test_head_backpressure();
        test_mid_backpressure();
        test_illegal_dest();
        test_over_length();
        test_exact_max();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatcher_for_in_req.md
Name: dispatcher_for_IN_req

Overview:
- Receive-side counterpart of the OUT_req upload arbiter. It drains multi-flit messages from the IN_req network FIFO and steers each one to exactly one download register: inst cache (ic), data cache (dc) or memory (mem).
- The destination is taken from the head flit and held until the tail flit (ctrl==2'b11).
- A message whose destination code is illegal, or that exceeds the length limit, is discarded.
- The flit datapath lives outside this block; this block drives the pop handshake, the per-target valids and a one-hot select.

Parameters:
- MAX_FLITS, 11, maximum flits per message including head and tail. Range 2..15.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- IN_req_rdy  input  1  IN_req FIFO holds a valid flit at its head.
- IN_req_ctrl  input  2  ctrl field of the head flit: 2'b11 = tail; any other value = non-tail.
- IN_req_dest  input  2  destination field, sampled only on a message's first flit: 00 = ic, 01 = dc, 10 = mem, 11 = illegal.
- ic_dl_rdy  input  1  ic download register can accept a flit this cycle.
- dc_dl_rdy  input  1  dc download register can accept a flit this cycle.
- mem_dl_rdy  input  1  mem download register can accept a flit this cycle.
- ack_IN_req  output  1  pop the IN_req FIFO this cycle (flit consumed).
- v_ic_dl  output  1  write the current flit into the ic download register.
- v_dc_dl  output  1  write the current flit into the dc download register.
- v_mem_dl  output  1  write the current flit into the mem download register.
- select  output  3  one-hot datapath mux: 100 = ic, 010 = dc, 001 = mem, 000 = none.
- err_dest  output  1  sticky flag: a message with dest 11 was seen.
- err_len  output  1  sticky flag: a message exceeded MAX_FLITS.

Behaviour:
- Registered state: FSM state (one-hot), flit counter flit_cnt[3:0], err_dest, err_len.
- ack_IN_req, v_*_dl and select are combinational (Mealy): same-cycle response, zero latency.
- Reset (rst low, asynchronous):
  - state = IDLE, flit_cnt = 0, err_dest = 0, err_len = 0.
  - While rst is low, all outputs are forced to 0 regardless of inputs.
  - Reset mid-message abandons it; the remaining flits are treated as a new message after reset releases.
- Defaults every cycle: all outputs 0, state holds.
- A flit is "accepted" in any cycle where ack_IN_req = 1.
- The rules for each state are:
  - IDLE, when IN_req_rdy = 1:
    - Decode IN_req_dest into target T.
    - T legal and T_rdy = 1: ack_IN_req = 1, v_T_dl = 1, select = T. If ctrl == 11 (single-flit message), stay in IDLE; otherwise go to T_DL with flit_cnt = 1.
    - T legal and T_rdy = 0: no ack, no valid; stay in IDLE (flit waits in the FIFO).
    - dest == 11: ack_IN_req = 1, no valid, select = 000, err_dest <= 1. If ctrl == 11, stay in IDLE; otherwise go to DROP.
  - IC_DL / DC_DL / MEM_DL (T fixed by state):
    - IN_req_rdy = 1 and T_rdy = 1: ack_IN_req = 1, v_T_dl = 1, select = T.
      - If ctrl == 11: go to IDLE, flit_cnt <= 0.
      - Else if flit_cnt + 1 == MAX_FLITS: err_len <= 1, go to DROP. The flit that reached the limit is still delivered.
      - Else: flit_cnt <= flit_cnt + 1.
    - Otherwise: hold state, all outputs 0. IN_req_dest is ignored.
    - A different target's rdy is never consulted.
  - DROP:
    - IN_req_rdy = 1: ack_IN_req = 1, no valid, select = 000.
    - If ctrl == 11: go to IDLE, flit_cnt <= 0.
    - No download-register rdy is consulted in this state.
- Invariants:
  - At most one v_*_dl is high in any cycle.
  - select is nonzero only when a v_*_dl is high, and then equals that target.
  - ack_IN_req is never high without IN_req_rdy.
- Message ordering is strictly FIFO. There is no arbitration here, because the single input stream is serialised.
- err_dest and err_len clear only on reset.

Test Plan:
- Pass-through:
  - Stimulus: 3-flit message, dest = 01, ctrl 00/00/11, dc_dl_rdy held 1.
  - Response: ack_IN_req and v_dc_dl high for 3 consecutive cycles, select = 010 throughout, state back to IDLE after the tail; v_ic_dl and v_mem_dl stay 0.
- Backpressure on head:
  - Stimulus: dest = 10, mem_dl_rdy = 0 for 4 cycles then 1.
  - Response: ack_IN_req = 0 for those 4 cycles; the head is accepted on the cycle mem_dl_rdy rises.
- Backpressure mid-message:
  - Stimulus: dest = 00, ic_dl_rdy drops after the head for 2 cycles, while dc_dl_rdy = 1 and IN_req_dest toggles.
  - Response: no ack for those 2 cycles; the message resumes to ic only.
- Illegal destination:
  - Stimulus: 2-flit message with dest = 11, then a 1-flit message with dest = 00 (ctrl 11).
  - Response: both illegal flits acked with all v_*_dl = 0 and err_dest = 1; the next message is delivered to ic, and the FSM returns to IDLE the same cycle.
- Over-length:
  - Stimulus: MAX_FLITS = 11, a 14-flit message to mem.
  - Response: flits 1..11 are written to mem; err_len rises after flit 11; flits 12..14 are acked and dropped; the FSM is in IDLE after flit 14.
- Async reset mid-message:
  - Stimulus: pull rst low between clock edges during a DC_DL transfer.
  - Response: all outputs 0 immediately; after release, state = IDLE and both error flags = 0.
